fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
Framebuffer write-side engine, the producer for the VGA scan-out path. Accepts a stream of 8-bit grayscale pixels in raster order, packs four per 32-bit word, and writes each word to framebuffer memory at word address = pixel_index >> 2. The byte layout matches the scan-out reader: the first pixel of each group is in bits [31:24] and the fourth is in bits [7:0]. Sits between the pixel source (rasteriser/CPU DMA) and the framebuffer RAM write port.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame; H_RES*V_RES must be a multiple of 4
ADDR_W, 32, width of the memory word address

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
px_data  in  8  grayscale pixel value
px_valid  in  1  px_data/px_sof valid this cycle
px_sof  in  1  marks first pixel (index 0) of a frame; qualified by px_valid
px_ready  out  1  engine accepts pixel this cycle (transfer = px_valid & px_ready)
mem_we  out  1  write request to framebuffer
mem_adr  out  ADDR_W  word address, pixel_index >> 2
mem_wdata  out  32  packed word, pixel 4k in [31:24] .. pixel 4k+3 in [7:0]
mem_ack  in  1  memory accepted the write; sampled only while mem_we=1
frame_done  out  1  one-cycle pulse after the last word of a frame is acked
sof_err  out  1  one-cycle pulse when px_sof arrives mid-frame

Behaviour:
- Reset (sync, rst=1 at a clock edge): state IDLE, pixel counter=0, lane=0, pack register=0, mem_we=0, mem_adr=0, mem_wdata=0, frame_done=0, sof_err=0.
- Reset mid-write: mem_we drops on the next edge and the partial word is lost. No write completes after reset.
- px_ready is decoded combinationally from state: 1 in IDLE and FILL, 0 in WRITE.
- IDLE: transfers without px_sof are consumed and discarded. A transfer with px_sof loads lane 0 (pack[31:24]), sets pixel counter=1, and goes to FILL.
- FILL: each transfer writes the pixel into lane (counter mod 4) and increments the counter.
  - When lane 3 is written, the word is registered on the same edge: mem_wdata = completed pack, mem_adr = (counter_before_increment) >> 2, mem_we=1. The state goes to WRITE.
  - Latency: mem_we rises on the edge that accepts the 4th pixel.
- WRITE: mem_we, mem_adr and mem_wdata are held stable until an edge with mem_ack=1. On that edge mem_we goes to 0.
  - If counter == H_RES*V_RES: pulse frame_done for 1 cycle, clear the counter, go to IDLE.
  - Otherwise go to FILL.
  - Minimum 1 cycle of mem_we. mem_ack while mem_we=0 is ignored.
  - Peak throughput is 4 pixels per 5 cycles with zero-wait memory.
- px_sof in FILL (counter != 0): pulse sof_err and discard the partial pack. The new pixel becomes pixel 0 (lane 0, counter=1) and the state stays in FILL.
- px_sof is not sampled in WRITE because px_ready=0 there.
- Last frame word: address (H_RES*V_RES/4)-1, which is 76799 at defaults. The counter never exceeds H_RES*V_RES, and addresses never wrap past the last word.
- Arithmetic: the counter is wide enough for H_RES*V_RES (19 bits at defaults). mem_adr is the counter >> 2, zero-extended to ADDR_W.
- Pack register lanes not yet written in the current word retain stale data. They are never written to memory except as part of a full word.

Test Plan:
- Reset, then sof pixel 0x11 followed by 0x22, 0x33, 0x44, mem_ack=1 constant -> one write: adr=0, wdata=0x11223344, mem_we high for exactly 1 cycle. px_ready=0 during that cycle.
- Pixels with px_sof=0 after reset, e.g. 0xAA x8 -> no writes, px_ready stays 1, counter remains 0.
- Full 640x480 frame of value (index & 0xFF), random ack delay 0-3 cycles -> 76800 writes with monotonically increasing addresses 0..76799, correct packing, mem_adr/mem_wdata stable while mem_we=1, single frame_done after the ack at adr 76799.
- Send 6 pixels, then a px_sof pixel 0x55 followed by 0x66, 0x77, 0x88 -> first write adr=0 wdata=0x........ (pixels 0-3), then sof_err pulse, then write adr=0 wdata=0x55667788.
- Hold mem_ack=0 for 10 cycles during WRITE while px_valid=1 -> px_ready=0, outputs stable, no pixels consumed. Write completes on the first ack.
- Assert rst during WRITE -> mem_we=0 on the next edge, all outputs at reset values, engine in IDLE awaiting px_sof.

Source files
------------

// File: rtl/fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pixel_writer
//  Description : Packs a raster stream of 8-bit grayscale pixels four per
//                32-bit word and writes each word to framebuffer memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_pixel_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        px_data,
    input  logic              px_valid,
    input  logic              px_sof,
    output logic              px_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int c_FRAME_PIX = H_RES * V_RES;
    localparam int c_CNT_W     = $clog2(c_FRAME_PIX + 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_CNT = c_CNT_W'(c_FRAME_PIX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    // Lanes 0..2 of the word under construction; lane 3 goes straight to mem_wdata.
    logic [23:0]         r_pack;
    logic                w_xfer;
    logic [1:0]          w_lane;

    assign px_ready = (r_state != ST_WRITE);
    assign w_xfer   = px_valid & px_ready;
    assign w_lane   = r_cnt[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pack     <= '0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sof_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && px_sof) begin
                        r_pack[23:16] <= px_data;
                        r_cnt         <= c_CNT_ONE;
                        r_state       <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (w_xfer) begin
                        if (px_sof) begin
                            // Restart the frame: the new pixel becomes pixel 0.
                            sof_err       <= 1'b1;
                            r_pack[23:16] <= px_data;
                            r_cnt         <= c_CNT_ONE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                            case (w_lane)
                                2'd0: r_pack[23:16] <= px_data;
                                2'd1: r_pack[15:8]  <= px_data;
                                2'd2: r_pack[7:0]   <= px_data;
                                default: begin
                                    mem_wdata <= {r_pack, px_data};
                                    mem_adr   <= ADDR_W'(r_cnt >> 2);
                                    mem_we    <= 1'b1;
                                    r_state   <= ST_WRITE;
                                end
                            endcase
                        end
                    end
                end

                ST_WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (r_cnt == c_FRAME_CNT) begin
                            frame_done <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state    <= ST_FILL;
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_pixel_writer
//  Description : Self-checking bench for fb_pixel_writer (reduced 40x30 frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pixel_writer;

    localparam int H_RES     = 40;
    localparam int V_RES     = 30;
    localparam int ADDR_W    = 32;
    localparam int FRAME_PIX = H_RES * V_RES;
    localparam int WORDS     = FRAME_PIX / 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        px_data = '0;
    logic              px_valid = 1'b0;
    logic              px_sof = 1'b0;
    logic              px_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic              frame_done;
    logic              sof_err;

    int checks = 0;
    int errors = 0;
    int seed   = 0;

    fb_pixel_writer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .px_data(px_data), .px_valid(px_valid), .px_sof(px_sof), .px_ready(px_ready),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Passive log of every write issued and every pulse seen.
    logic [ADDR_W-1:0] log_adr[$];
    logic [31:0]       log_wd[$];
    int                n_sof_err = 0;
    int                n_fd = 0;
    logic              log_prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we && !log_prev_we) begin
            log_adr.push_back(mem_adr);
            log_wd.push_back(mem_wdata);
        end
        if (sof_err)    n_sof_err <= n_sof_err + 1;
        if (frame_done) n_fd <= n_fd + 1;
        log_prev_we <= mem_we;
    end

    function automatic logic [7:0] px_val(input int i);
        return 8'((i ^ seed) & 255);
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        return {px_val(4*a), px_val(4*a+1), px_val(4*a+2), px_val(4*a+3)};
    endfunction

    task automatic do_reset();
        rst = 1'b1; px_valid = 1'b0; px_sof = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_adr.delete(); log_wd.delete();
        n_sof_err = 0; n_fd = 0;
    endtask

    // Holds the pixel until accepted; returns on the negedge after the accepting edge.
    task automatic send_px(input logic [7:0] d, input logic s);
        logic rdy;
        px_data = d; px_sof = s; px_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            rdy = px_ready;
            @(negedge clk);
            if (rdy) begin
                px_valid = 1'b0; px_sof = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_px_timeout px_ready stayed %b, required 1", px_ready);
        px_valid = 1'b0; px_sof = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL reset_we got %b want 0", mem_we); end
        checks++; if (mem_adr !== '0)    begin errors++; $display("FAIL reset_adr got %h want 0", mem_adr); end
        checks++; if (mem_wdata !== '0)  begin errors++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
        checks++; if (sof_err !== 1'b0)  begin errors++; $display("FAIL reset_sof_err got %b want 0", sof_err); end
        checks++; if (px_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", px_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        mem_ack = 1'b1;
        send_px(8'h11, 1'b1); send_px(8'h22, 1'b0); send_px(8'h33, 1'b0);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_early_we got %b want 0", mem_we); end
        send_px(8'h44, 1'b0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL basic_we got %b want 1", mem_we); end
        checks++; if (mem_adr !== 32'd0) begin errors++; $display("FAIL basic_adr got %h want 0", mem_adr); end
        checks++; if (mem_wdata !== 32'h11223344) begin errors++; $display("FAIL basic_wdata got %h want 11223344", mem_wdata); end
        checks++; if (px_ready !== 1'b0) begin errors++; $display("FAIL basic_ready got %b want 0", px_ready); end
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_we_len got %b want 0", mem_we); end
        checks++; if (log_adr.size() !== 1) begin errors++; $display("FAIL basic_nwrites got %0d want 1", log_adr.size()); end
        mem_ack = 1'b0;
    endtask

    task automatic test_no_sof();
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            px_valid = 1'b1; px_data = 8'hAA; px_sof = 1'b0;
            @(negedge clk);
            checks++;
            if (px_ready !== 1'b1 || mem_we !== 1'b0) begin
                errors++; $display("FAIL nosof_idle ready=%b we=%b want ready=1 we=0", px_ready, mem_we);
            end
        end
        px_valid = 1'b0;
        send_px(8'h01, 1'b1); send_px(8'h02, 1'b0); send_px(8'h03, 1'b0); send_px(8'h04, 1'b0);
        checks++;
        if (mem_we !== 1'b1 || mem_adr !== 32'd0 || mem_wdata !== 32'h01020304) begin
            errors++; $display("FAIL nosof_first_word we=%b adr=%h wdata=%h want 1/0/01020304", mem_we, mem_adr, mem_wdata);
        end
        @(negedge clk);
        checks++; if (log_adr.size() !== 1) begin errors++; $display("FAIL nosof_nwrites got %0d want 1", log_adr.size()); end
        mem_ack = 1'b0;
    endtask

    task automatic test_sof_err();
        logic [7:0] p[6];
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) p[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) send_px(p[i], i == 0);
        send_px(8'h55, 1'b1); send_px(8'h66, 1'b0); send_px(8'h77, 1'b0); send_px(8'h88, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (n_sof_err !== 1) begin errors++; $display("FAIL soferr_pulses got %0d want 1", n_sof_err); end
        checks++;
        if (log_adr.size() !== 2) begin
            errors++; $display("FAIL soferr_nwrites got %0d want 2", log_adr.size());
        end else begin
            checks++;
            if (log_adr[0] !== 32'd0 || log_wd[0] !== {p[0], p[1], p[2], p[3]}) begin
                errors++; $display("FAIL soferr_word0 adr=%h wdata=%h want 0/%h", log_adr[0], log_wd[0], {p[0], p[1], p[2], p[3]});
            end
            checks++;
            if (log_adr[1] !== 32'd0 || log_wd[1] !== 32'h55667788) begin
                errors++; $display("FAIL soferr_word1 adr=%h wdata=%h want 0/55667788", log_adr[1], log_wd[1]);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        do_reset();
        w = $urandom;
        mem_ack = 1'b0;
        send_px(w[31:24], 1'b1); send_px(w[23:16], 1'b0); send_px(w[15:8], 1'b0); send_px(w[7:0], 1'b0);
        px_valid = 1'b1; px_data = 8'hEE; px_sof = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (px_ready !== 1'b0 || mem_we !== 1'b1 || mem_adr !== 32'd0 || mem_wdata !== w) begin
                errors++; $display("FAIL stall_hold ready=%b we=%b adr=%h wdata=%h want 0/1/0/%h", px_ready, mem_we, mem_adr, mem_wdata, w);
            end
            @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || px_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release we=%b ready=%b want 0/1", mem_we, px_ready);
        end
        send_px(8'hEE, 1'b0); send_px(8'h01, 1'b0); send_px(8'h02, 1'b0); send_px(8'h03, 1'b0);
        @(negedge clk);
        checks++;
        if (log_adr.size() !== 2) begin
            errors++; $display("FAIL stall_nwrites got %0d want 2", log_adr.size());
        end else begin
            checks++;
            if (log_adr[1] !== 32'd1 || log_wd[1] !== 32'hEE010203) begin
                errors++; $display("FAIL stall_word1 adr=%h wdata=%h want 1/ee010203", log_adr[1], log_wd[1]);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        mem_ack = 1'b0;
        send_px(8'hA1, 1'b1); send_px(8'hA2, 1'b0); send_px(8'hA3, 1'b0); send_px(8'hA4, 1'b0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we got %b want 1", mem_we); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || mem_adr !== '0 || mem_wdata !== '0 || px_ready !== 1'b1 ||
            frame_done !== 1'b0 || sof_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs we=%b adr=%h wdata=%h ready=%b fd=%b se=%b want 0/0/0/1/0/0",
                               mem_we, mem_adr, mem_wdata, px_ready, frame_done, sof_err);
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) send_px(8'hB0 + 8'(i), 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_idle_we got %b want 0", mem_we); end
        send_px(8'hC1, 1'b1); send_px(8'hC2, 1'b0); send_px(8'hC3, 1'b0); send_px(8'hC4, 1'b0);
        @(negedge clk);
        checks++;
        if (log_adr.size() !== 2) begin
            errors++; $display("FAIL rstmid_nwrites got %0d want 2", log_adr.size());
        end else begin
            checks++;
            if (log_adr[1] !== 32'd0 || log_wd[1] !== 32'hC1C2C3C4) begin
                errors++; $display("FAIL rstmid_word adr=%h wdata=%h want 0/c1c2c3c4", log_adr[1], log_wd[1]);
            end
        end
        mem_ack = 1'b0;
    endtask

    // Whole frame with random source gaps and random ack latency 0..3.
    task automatic test_full_frame();
        int src, exp_adr, ack_wait, ack_delay, fd_seen, tail;
        logic we, rdy, fd, prev_we, prev_rdy, last_ack;
        logic [ADDR_W-1:0] adr, prev_adr;
        logic [31:0] wd, prev_wd;
        do_reset();
        seed = int'($urandom_range(0, 255));
        src = 0; exp_adr = 0; ack_wait = 0; ack_delay = 0; fd_seen = 0; tail = 0;
        prev_we = 1'b0; prev_rdy = 1'b1; last_ack = 1'b0; prev_adr = '0; prev_wd = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            we = mem_we; adr = mem_adr; wd = mem_wdata; rdy = px_ready; fd = frame_done;
            if (px_valid && prev_rdy) src++;
            if (fd || last_ack) begin
                checks++;
                if (fd !== last_ack) begin
                    errors++; $display("FAIL frame_done_timing got %b want %b at word %0d", fd, last_ack, exp_adr);
                end
            end
            if (fd) fd_seen++;
            if (we && !prev_we) begin
                checks++;
                if (adr !== ADDR_W'(exp_adr) || wd !== exp_word(exp_adr)) begin
                    errors++; $display("FAIL frame_word adr=%h wdata=%h want %h/%h", adr, wd, exp_adr, exp_word(exp_adr));
                end
                exp_adr++;
                ack_delay = int'($urandom_range(0, 3));
                ack_wait = 0;
            end else if (we) begin
                checks++;
                if (adr !== prev_adr || wd !== prev_wd) begin
                    errors++; $display("FAIL frame_hold adr=%h wdata=%h want %h/%h", adr, wd, prev_adr, prev_wd);
                end
            end
            checks++;
            if (rdy !== !we) begin
                errors++; $display("FAIL frame_ready got %b want %b", rdy, !we);
            end
            last_ack = 1'b0;
            if (we) begin
                mem_ack = (ack_wait == ack_delay);
                ack_wait++;
                last_ack = mem_ack && (exp_adr == WORDS);
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            if (src < FRAME_PIX) begin
                px_valid = ($urandom_range(0, 3) != 0);
                px_data  = px_val(src);
                px_sof   = (src == 0);
            end else begin
                px_valid = 1'b0; px_sof = 1'b0;
            end
            prev_we = we; prev_adr = adr; prev_wd = wd; prev_rdy = rdy;
            if (fd_seen > 0) tail++;
            if (tail > 4) break;
            @(negedge clk);
        end
        px_valid = 1'b0; px_sof = 1'b0; mem_ack = 1'b0;
        checks++; if (exp_adr !== WORDS) begin errors++; $display("FAIL frame_nwrites got %0d want %0d", exp_adr, WORDS); end
        checks++; if (fd_seen !== 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fd_seen); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_no_sof();
        test_sof_err();
        test_backpressure();
        test_reset_mid_write();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
